// File: rtl/glyph_loader.sv
// RLE-fed glyph RAM loader: writes a 2048 x 3-bit glyph RAM from run-length tokens and exposes an async read port.
// Optional GLYPH_LOADER_SUM_EN adds chk, a running mod-2**16 sum of written colours.
module glyph_loader #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 3,
  parameter int COUNT_W = 5   // DATA_W + COUNT_W must be 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  input  logic              rd_sym,
  input  logic [4:0]        rd_x,
  input  logic [4:0]        rd_y,
  output logic [DATA_W-1:0] rd_data
`ifdef GLYPH_LOADER_SUM_EN
  ,
  output logic [15:0]       chk
`endif
);

  typedef enum logic [1:0] {IDLE, ACCEPT, RUN, DONE} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    ptr;
  logic [DATA_W-1:0]    colour;
  logic [COUNT_W-1:0]   remaining;
  logic [DATA_W-1:0]    mem [2**ADDR_W];
  logic [ADDR_W-1:0]    rd_addr;
  logic                 we;
  logic                 ptr_last;

  assign ptr_last = &ptr;
  // An aborting start wins over the pending write of that cycle.
  assign we       = (state == RUN) && !start;
  assign rd_addr  = ADDR_W'({rd_sym, rd_y, rd_x});
  assign rd_data  = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (we) mem[ptr] <= colour;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      colour    <= '0;
      remaining <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
`ifdef GLYPH_LOADER_SUM_EN
      chk       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= ACCEPT;
        ptr      <= '0;
        overflow <= 1'b0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
`ifdef GLYPH_LOADER_SUM_EN
        chk      <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
          ACCEPT: begin
            if (in_valid) begin
              colour    <= in_data[DATA_W-1:0];
              remaining <= in_data[DATA_W +: COUNT_W];
              in_ready  <= 1'b0;
              state     <= RUN;
            end
          end
          RUN: begin
            ptr <= ptr + 1'b1;
`ifdef GLYPH_LOADER_SUM_EN
            chk <= chk + 16'(colour);
`endif
            if (ptr_last) begin
              // Last address: finish, flagging a truncated run rather than wrapping.
              overflow <= overflow | (remaining != '0);
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else if (remaining == '0) begin
              in_ready <= 1'b1;
              state    <= ACCEPT;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
          DONE: begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glyph_loader.sv
// Directed bench for glyph_loader: fill, mixed runs, overflow, restart, read-during-write.
module tb_glyph_loader;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, rd_sym, in_ready, busy, done, overflow;
  logic [7:0] in_data;
  logic [4:0] rd_x, rd_y;
  logic [2:0] rd_data;
`ifdef GLYPH_LOADER_SUM_EN
  logic [15:0] chk;
`endif

  int n_asrt = 0;
  int n_fail = 0;
  int done_cnt = 0;

  glyph_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .done(done), .overflow(overflow),
    .rd_sym(rd_sym), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data)
`ifdef GLYPH_LOADER_SUM_EN
    , .chk(chk)
`endif
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Offer a token after a gap, hold it until accepted; returns at the negedge after acceptance.
  task automatic send_token(input logic [7:0] tok, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_data  = tok;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("token_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_runs(input logic [7:0] tok, input int cnt);
    for (int i = 0; i < cnt; i++) send_token(tok, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic rd(input logic [10:0] a, output logic [2:0] d);
    {rd_sym, rd_y, rd_x} = a;
    #1 d = rd_data;
  endtask

  initial begin
    int n, bad, dc0;
    logic [2:0] d;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_sym = 1'b0; rd_x = '0; rd_y = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full uniform fill, colour 5
    pulse_start();
    check("start_ready", 32'(in_ready), 1);
    check("start_busy", 32'(busy), 1);
    dc0 = done_cnt;
    send_runs(8'hFD, 64);
    wait_done(n);
    check("fill_done_lat", 32'(n), 32);
    @(negedge clk);
    check("fill_done_1cyc", 32'(done), 0);
    check("fill_busy_end", 32'(busy), 0);
    check("fill_done_cnt", 32'(done_cnt - dc0), 1);
    check("fill_ovf", 32'(overflow), 0);
`ifdef GLYPH_LOADER_SUM_EN
    check("fill_chk", 32'(chk), 10240);
`endif
    bad = 0;
    for (int a = 0; a < 2048; a++) begin
      rd(11'(a), d);
      if (d !== 3'd5) bad++;
    end
    check("fill_read_bad", 32'(bad), 0);

    // Idle ignores tokens without start
    in_data = 8'h00; in_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_ready", 32'(in_ready), 0);
    check("idle_busy", 32'(busy), 0);
    in_valid = 1'b0;
    rd(11'd0, d);
    check("idle_nowrite", 32'(d), 5);

    // Mixed runs with gapped valid
    pulse_start();
    repeat (3) @(negedge clk);
    check("mix_hold_ready", 32'(in_ready), 1);
    send_token(8'h02, int'($urandom_range(1, 4)));
    check("mix_run_ready", 32'(in_ready), 0);
    send_token(8'h0B, int'($urandom_range(1, 4)));
    check("mix_run2_ready", 32'(in_ready), 0);
    check("mix_run2_busy", 32'(busy), 1);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("mix_back_accept", 32'(n), 2);
    rd(11'd0, d); check("mix_a0", 32'(d), 2);
    rd(11'd1, d); check("mix_a1", 32'(d), 3);
    rd(11'd2, d); check("mix_a2", 32'(d), 3);
    rd(11'd3, d); check("mix_a3", 32'(d), 5);

    // Overflow truncation: 2047 px of colour 6, then 5 px of colour 7
    pulse_start();
    dc0 = done_cnt;
    send_runs(8'hFE, 63);
    send_token(8'hF6, 0);
    send_token(8'h27, 0);
    wait_done(n);
    check("ovf_done_lat", 32'(n), 1);
    check("ovf_flag", 32'(overflow), 1);
    rd(11'd2047, d); check("ovf_a2047", 32'(d), 7);
    rd(11'd2046, d); check("ovf_a2046", 32'(d), 6);
    rd(11'd0, d);    check("ovf_a0", 32'(d), 6);
`ifdef GLYPH_LOADER_SUM_EN
    check("ovf_chk", 32'(chk), 12289);
`endif
    repeat (5) @(negedge clk);
    check("ovf_ready_after", 32'(in_ready), 0);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_done_cnt", 32'(done_cnt - dc0), 1);

    // Read during write: addr 0 holds 6, new pixel colour 4
    pulse_start();
    check("rdw_ovf_clr", 32'(overflow), 0);
    send_token(8'h04, 0);
    rd(11'd0, d); check("rdw_before", 32'(d), 6);
    @(posedge clk);
    #1 check("rdw_after", 32'(rd_data), 4);
    @(negedge clk);

    // Restart mid-load
    pulse_start();
    send_runs(8'hF9, 3);
    send_token(8'h19, 0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("rs_busy", 32'(busy), 1);
    check("rs_ready", 32'(in_ready), 1);
    dc0 = done_cnt;
    send_token(8'h12, 0);
    send_runs(8'hFA, 63);
    send_token(8'hE2, 0);
    wait_done(n);
    check("rs_done_lat", 32'(n), 29);
    check("rs_ovf", 32'(overflow), 0);
`ifdef GLYPH_LOADER_SUM_EN
    check("rs_chk", 32'(chk), 4096);
`endif
    @(negedge clk);
    check("rs_done_cnt", 32'(done_cnt - dc0), 1);
    rd(11'd0, d);    check("rs_a0", 32'(d), 2);
    rd(11'd2047, d); check("rs_a2047", 32'(d), 2);

    // Asynchronous reset mid-load
    pulse_start();
    #2 rst = 1'b1;
    #1 check("arst_ready", 32'(in_ready), 0);
    check("arst_busy", 32'(busy), 0);
    @(negedge clk) rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_loader.md
Name: glyph_loader

Overview:
- Write-side counterpart of the character ROM: owns a writable 2048 x 3-bit glyph RAM.
- Fills the RAM from a byte stream of run-length-encoded pixels.
- Exposes the same combinational read port ({sym, yaddr, xaddr} -> 3-bit colour index) to the pixel pipeline.
- Lets the demo replace both glyphs at runtime instead of relying on a synthesis-time image.

Parameters:
- ADDR_W, 11, RAM address width; linear address = {sym, yaddr[4:0], xaddr[4:0]}; depth = 2**ADDR_W.
- DATA_W, 3, pixel (palette index) width.
- COUNT_W, 5, run-length field width; DATA_W + COUNT_W must equal 8.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: begin (or restart) a load at address 0.
- in_data  in  8  RLE token: [7:3] = count, [2:0] = colour; run length = count+1 (1..32).
- in_valid  in  1  in_data valid.
- in_ready  out  1  token accepted on an edge where in_valid & in_ready.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes.
- overflow  out  1  sticky; the last token's run extended past address 2047.
- rd_sym  in  1  read glyph select.
- rd_x  in  5  read column.
- rd_y  in  5  read row.
- rd_data  out  3  RAM[{rd_sym, rd_y, rd_x}], combinational.

Behaviour:
- Reset (async, rst=1): state IDLE, in_ready=0, busy=0, done=0, overflow=0, write pointer ptr=0. RAM contents are not reset and are undefined until first load.
- States: IDLE, ACCEPT, RUN, DONE.
- IDLE: in_ready=0, busy=0. start -> ACCEPT, ptr=0, overflow=0.
- ACCEPT: in_ready=1, busy=1. On in_valid:
  - latch colour=in_data[2:0] and remaining=in_data[7:3];
  - go to RUN.
  - No write occurs in this cycle.
- RUN: in_ready=0, busy=1. Each edge:
  - write colour at ptr, then ptr += 1;
  - if remaining==0: go to DONE if ptr was 2047, else ACCEPT;
  - else remaining -= 1, but if ptr was 2047 with remaining != 0: set overflow=1, go to DONE (run truncated, no wrap).
- DONE: done=1 for exactly this one cycle, busy=0, in_ready=0. Next state IDLE.
- Throughput: a token of count c occupies 1 accept cycle + (c+1) write cycles.
- Latency:
  - start at edge N -> in_ready=1 during cycle N+1.
  - A token accepted at edge M writes its first pixel at edge M+1.
- A full load of 2048 pixels ends with done asserted the cycle after the edge that writes address 2047.
- start has priority in every state:
  - abort, ptr=0, overflow=0, go to ACCEPT;
  - any token offered in the same cycle is not accepted;
  - pixels already written remain in RAM.
- ptr is ADDR_W bits. A write at 2047 never wraps to 0 within one load.
- Read port:
  - asynchronous read, independent of load state;
  - a read of the address being written in the same cycle returns the old value;
  - the new value is visible after the edge.
- in_valid without in_ready is ignored; the producer holds the token.

Optional Feature:
- Macro GLYPH_LOADER_SUM_EN.
- When defined:
  - extra output port chk (out, 16) = running modulo-2**16 sum of every colour value written since the last start;
  - cleared to 0 by rst and by start;
  - updated on each RUN write edge;
  - stable after done.
- When undefined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse -> busy=0, done=0, in_ready=0, overflow=0; no RAM writes with in_valid=1 and no start.
- Full uniform fill: start, then 64 tokens of 0xFD (count 31, colour 5) -> done pulses once after address 2047 is written; every rd_sym/rd_x/rd_y reads 5; overflow=0; chk=10240 (mod 2**16 = 10240) if GLYPH_LOADER_SUM_EN.
- Mixed runs and backpressure: start, tokens 0x02 (1 px colour 2) then 0x0B (2 px colour 3), with in_valid gapped randomly -> addr0=2, addr1=3, addr2=3; in_ready is high only in ACCEPT; token hold is respected.
- Overflow truncation: load 2047 pixels, then token 0x27 (5 px colour 7) -> only addr 2047=7; overflow=1; done pulses; in_ready stays 0 afterwards.
- Restart mid-load:
  - first load: start, write 100 pixels of colour 1, assert start while in RUN -> busy stays 1, next token lands at address 0;
  - second load completes normally -> done; overflow=0.
- Read during write: hold rd address 0 while the first pixel (colour 4) is written over old value 6 -> rd_data=6 before the edge, 4 after.
